// File: rtl/scope_pkg.sv
// ---------------------------------------------------------------------------
// scope_pkg
// Shared definitions for the oscilloscope capture path: default geometry of
// the sample banks and the capture controller state encoding.
// ---------------------------------------------------------------------------
package scope_pkg;

   localparam int SAMPLE_W = 14;
   localparam int DEPTH    = 800;
   localparam int ADDR_W   = 10;
   localparam int SCREEN_W = 800;

   // Capture controller states, 2-bit encoding
   typedef enum logic [1:0] {
      IDLE     = 2'd0,
      TRIGWAIT = 2'd1,
      CAPTURE  = 2'd2,
      DONE     = 2'd3
   } capState_e;

endpackage

// File: rtl/sample_bank_ram.sv
// ---------------------------------------------------------------------------
// sample_bank_ram
// Ping-pong sample storage: two banks of 2^ADDR_W samples in one simple
// dual-port memory. The bank select forms the address MSB so one bank can be
// written while the other is displayed.
//
// Ports:
//   clk        system clock
//   rst_n      synchronous active-low reset (clears the read register only)
//   wrEn_i     write strobe
//   wrBank_i   bank being written
//   wrAddr_i   write address inside the bank
//   wrData_i   sample to store
//   rdEn_i     read enable; read register holds its value when low
//   rdBank_i   bank being read
//   rdAddr_i   read address inside the bank
//   rdData_o   registered read data, one cycle after the address
// ---------------------------------------------------------------------------
module sample_bank_ram #(
   parameter int SAMPLE_W = 14,
   parameter int ADDR_W   = 10
) (
   input  logic                clk,
   input  logic                rst_n,
   input  logic                wrEn_i,
   input  logic                wrBank_i,
   input  logic [ADDR_W-1:0]   wrAddr_i,
   input  logic [SAMPLE_W-1:0] wrData_i,
   input  logic                rdEn_i,
   input  logic                rdBank_i,
   input  logic [ADDR_W-1:0]   rdAddr_i,
   output logic [SAMPLE_W-1:0] rdData_o
);

   logic [SAMPLE_W-1:0] mem [0:(2**(ADDR_W+1))-1];
   logic [SAMPLE_W-1:0] rdData_q;

   // Write port: no reset on the array so it maps onto block RAM
   always_ff @(posedge clk) begin
      if (wrEn_i) begin
         mem[{wrBank_i, wrAddr_i}] <= wrData_i;
      end
   end

   // Registered read port; holding on rdEn_i = 0 keeps the last value on
   // the output while the pixel column is outside the trace
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         rdData_q <= '0;
      end else if (rdEn_i) begin
         rdData_q <= mem[{rdBank_i, rdAddr_i}];
      end
   end

   assign rdData_o = rdData_q;

endmodule

// File: rtl/wave_capture_ctrl.sv
// ---------------------------------------------------------------------------
// wave_capture_ctrl
// Sequences oscilloscope capture into a ping-pong sample RAM: trigger
// detection, auto-trigger timeout and decimation fill the back bank, and the
// banks swap only on a vblank rising edge so the displayed trace never tears.
// The front bank is read per pixel column for the wave renderer.
//
// Ports:
//   clk, rst_n     clock, synchronous active-low reset
//   run            1 = acquire, 0 = freeze after any capture in progress
//   auto_mode      1 = force a capture after AUTO_TO samples without trigger
//   trig_rising    trigger edge select (1 rising, 0 falling)
//   trig_level     unsigned trigger threshold
//   decim          keep 1 of every decim valid samples (0 behaves as 1)
//   sample_in      ADC sample, qualified by sample_valid
//   vblank         vertical blank from the sync generator
//   pix_x          current pixel column
//   wave_out       front-bank sample at pix_x, one cycle later
//   wave_en        wave_out is a displayable sample
//   busy           waiting for a trigger or capturing
//   triggered      last capture came from a real trigger (0 = auto)
// ---------------------------------------------------------------------------
module wave_capture_ctrl #(
   parameter int SAMPLE_W = scope_pkg::SAMPLE_W,
   parameter int DEPTH    = scope_pkg::DEPTH,
   parameter int ADDR_W   = scope_pkg::ADDR_W,
   parameter int AUTO_TO  = 200000
) (
   input  logic                clk,
   input  logic                rst_n,
   input  logic                run,
   input  logic                auto_mode,
   input  logic                trig_rising,
   input  logic [SAMPLE_W-1:0] trig_level,
   input  logic [7:0]          decim,
   input  logic [SAMPLE_W-1:0] sample_in,
   input  logic                sample_valid,
   input  logic                vblank,
   input  logic [10:0]         pix_x,
   output logic [SAMPLE_W-1:0] wave_out,
   output logic                wave_en,
   output logic                busy,
   output logic                triggered
);

   import scope_pkg::*;

   localparam int CNT_W = $clog2(AUTO_TO + 1);

   capState_e           state_q;
   logic                frontBank_q;
   logic                haveFrame_q;
   logic                vblankDly_q;
   logic [SAMPLE_W-1:0] prev_q;
   logic [CNT_W-1:0]    autoCnt_q;
   logic [7:0]          decimLatch_q;
   logic [7:0]          decimCnt_q;
   logic [ADDR_W-1:0]   wrAddr_q;
   logic                busy_q;
   logic                triggered_q;
   logic                waveEn_q;

   logic                vblankRise;
   logic                trigHit;
   logic                autoHit;
   logic                startCapture;
   logic                keepSample;
   logic                lastWrite;
   logic                pixInRange;
   logic                wrEn;
   logic [ADDR_W-1:0]   wrAddr;

   // Event decode for the controller. The auto counter holds the number of
   // earlier valid samples, so the current one is number autoCnt_q+1.
   // Saturating the counter lets auto mode fire on the next sample if it is
   // switched on after the timeout has already elapsed.
   always_comb begin
      vblankRise   = vblank & ~vblankDly_q;
      trigHit      = sample_valid &
                     (trig_rising ? ((prev_q <  trig_level) && (sample_in >= trig_level))
                                  : ((prev_q >= trig_level) && (sample_in <  trig_level)));
      autoHit      = sample_valid & auto_mode & (autoCnt_q >= CNT_W'(AUTO_TO - 1));
      startCapture = (state_q == TRIGWAIT) & run & (trigHit | autoHit);
      keepSample   = (state_q == CAPTURE) & sample_valid &
                     ((decimCnt_q + 8'd1) == decimLatch_q);
      lastWrite    = keepSample & (wrAddr_q == ADDR_W'(DEPTH - 1));
      wrEn         = startCapture | keepSample;
      wrAddr       = startCapture ? '0 : wrAddr_q;
      pixInRange   = (pix_x < 11'(DEPTH));
   end

   // Capture controller: state, counters and the registered status outputs.
   // The first kept sample (trigger or auto) goes to address 0 directly, so
   // the write pointer starts at 1 on entry to CAPTURE. A capture finishing
   // on a vblank rise only reaches DONE at that edge, so it waits for the
   // following frame before swapping.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q      <= IDLE;
         frontBank_q  <= 1'b0;
         haveFrame_q  <= 1'b0;
         vblankDly_q  <= 1'b0;
         prev_q       <= '0;
         autoCnt_q    <= '0;
         decimLatch_q <= 8'd1;
         decimCnt_q   <= '0;
         wrAddr_q     <= '0;
         busy_q       <= 1'b0;
         triggered_q  <= 1'b0;
      end else begin
         vblankDly_q <= vblank;
         if (sample_valid) begin
            prev_q <= sample_in;
         end
         case (state_q)
            IDLE: begin
               if (run) begin
                  state_q   <= TRIGWAIT;
                  autoCnt_q <= '0;
                  busy_q    <= 1'b1;
               end
            end
            TRIGWAIT: begin
               if (!run) begin
                  state_q <= IDLE;
                  busy_q  <= 1'b0;
               end else if (startCapture) begin
                  state_q      <= CAPTURE;
                  triggered_q  <= trigHit;
                  decimLatch_q <= (decim == 8'd0) ? 8'd1 : decim;
                  decimCnt_q   <= '0;
                  wrAddr_q     <= ADDR_W'(1);
               end else if (sample_valid && (autoCnt_q < CNT_W'(AUTO_TO))) begin
                  autoCnt_q <= autoCnt_q + CNT_W'(1);
               end
            end
            CAPTURE: begin
               if (sample_valid) begin
                  if (keepSample) begin
                     decimCnt_q <= '0;
                     if (lastWrite) begin
                        state_q <= DONE;
                        busy_q  <= 1'b0;
                     end else begin
                        wrAddr_q <= wrAddr_q + ADDR_W'(1);
                     end
                  end else begin
                     decimCnt_q <= decimCnt_q + 8'd1;
                  end
               end
            end
            DONE: begin
               if (vblankRise) begin
                  frontBank_q <= ~frontBank_q;
                  haveFrame_q <= 1'b1;
                  if (run) begin
                     state_q   <= TRIGWAIT;
                     autoCnt_q <= '0;
                     busy_q    <= 1'b1;
                  end else begin
                     state_q <= IDLE;
                  end
               end
            end
            default: begin
               state_q <= IDLE;
               busy_q  <= 1'b0;
            end
         endcase
      end
   end

   // Display enable, registered so it lines up with the RAM read data
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         waveEn_q <= 1'b0;
      end else begin
         waveEn_q <= haveFrame_q & pixInRange;
      end
   end

   // Capture writes the back bank while the front bank feeds the display
   sample_bank_ram #(
      .SAMPLE_W (SAMPLE_W),
      .ADDR_W   (ADDR_W)
   ) u_ram (
      .clk      (clk),
      .rst_n    (rst_n),
      .wrEn_i   (wrEn),
      .wrBank_i (~frontBank_q),
      .wrAddr_i (wrAddr),
      .wrData_i (sample_in),
      .rdEn_i   (pixInRange),
      .rdBank_i (frontBank_q),
      .rdAddr_i (pix_x[ADDR_W-1:0]),
      .rdData_o (wave_out)
   );

   assign wave_en   = waveEn_q;
   assign busy      = busy_q;
   assign triggered = triggered_q;

endmodule

// File: tb/tb_wave_capture_ctrl.sv
// ---------------------------------------------------------------------------
// tb_wave_capture_ctrl
// Bench for wave_capture_ctrl with AUTO_TO shortened to 1000. A behavioural
// model of the scope (two sample arrays, a capture list with modulo
// decimation) predicts every output each cycle; directed phases pin the
// model with hand-computed values, then a randomized phase exercises mixes.
// ---------------------------------------------------------------------------
module tb_wave_capture_ctrl;

   localparam int SW     = 14;
   localparam int DEPTH  = 800;
   localparam int AW     = 10;
   localparam int AUTO   = 1000;
   localparam int PERIOD = 1100;
   localparam int VBLEN  = 30;

   localparam int P_IDLE = 0;
   localparam int P_WAIT = 1;
   localparam int P_CAP  = 2;
   localparam int P_DONE = 3;

   logic          clk = 1'b0;
   logic          rst_n;
   logic          run;
   logic          auto_mode;
   logic          trig_rising;
   logic [SW-1:0] trig_level;
   logic [7:0]    decim;
   logic [SW-1:0] sample_in;
   logic          sample_valid;
   logic          vblank;
   logic [10:0]   pix_x;
   logic [SW-1:0] wave_out;
   logic          wave_en;
   logic          busy;
   logic          triggered;

   int checks = 0;
   int errors = 0;

   // Stimulus knobs, copied onto the DUT inputs once per cycle
   int rstKnob = 0, runKnob = 0, autoKnob = 0, risingKnob = 1;
   int levelKnob = 8192, decimKnob = 1;
   int streamMode = 0, rampVal = 0, constVal = 100, validPct = 100;
   int pixMode = 0, pixFixed = 0;
   int vbMode = 0, frameCnt = 0;

   // Behavioural scope model
   int mPhase = P_IDLE;
   int mBank    [2][DEPTH];
   bit mWritten [2][DEPTH];
   int mFront = 0, mPrev = 0, mWaitCnt = 0, mSinceTrig = 0, mKeep = 1, mWrIdx = 0;
   int swapCount = 0;
   bit mHave = 0, mVbPrev = 0, mTrig = 0, mBusy = 0;
   int expOut = 0;
   bit expOutKnown = 0, expEn = 0, modelReady = 0;

   always #5 clk = ~clk;

   wave_capture_ctrl #(
      .SAMPLE_W (SW),
      .DEPTH    (DEPTH),
      .ADDR_W   (AW),
      .AUTO_TO  (AUTO)
   ) dut (
      .clk          (clk),
      .rst_n        (rst_n),
      .run          (run),
      .auto_mode    (auto_mode),
      .trig_rising  (trig_rising),
      .trig_level   (trig_level),
      .decim        (decim),
      .sample_in    (sample_in),
      .sample_valid (sample_valid),
      .vblank       (vblank),
      .pix_x        (pix_x),
      .wave_out     (wave_out),
      .wave_en      (wave_en),
      .busy         (busy),
      .triggered    (triggered)
   );

   task automatic compare(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("[TB] FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
      end
   endtask

   task automatic timeoutFail(input string name);
      checks++;
      errors++;
      $display("[TB] FAIL %s: timed out, got no event, expected one", name);
   endtask

   // Drive the knobs onto the DUT; the sync vblank mode raises vblank on
   // exactly the sample that completes the capture
   task automatic applyStimulus();
      bit completing;
      rst_n        = rstKnob[0];
      run          = runKnob[0];
      auto_mode    = autoKnob[0];
      trig_rising  = risingKnob[0];
      trig_level   = SW'(levelKnob);
      decim        = 8'(decimKnob);
      sample_valid = ($urandom_range(0, 99) < validPct);
      case (streamMode)
         0:       sample_in = SW'(rampVal);
         1:       sample_in = SW'(constVal);
         default: sample_in = SW'($urandom_range(0, 16383));
      endcase
      if (sample_valid && streamMode == 0) rampVal = (rampVal + 16) % 16384;
      pix_x = (pixMode != 0) ? 11'(pixFixed) : 11'($urandom_range(0, 1039));
      if (vbMode == 1) begin
         completing = modelReady && rstKnob != 0 && mPhase == P_CAP && sample_valid &&
                      ((mSinceTrig + 1) % mKeep == 0) && (mWrIdx == DEPTH - 1);
         if (completing) begin
            vblank   = 1'b1;
            vbMode   = 0;
            frameCnt = 1;
         end else begin
            vblank = 1'b0;
         end
      end else begin
         vblank   = ((frameCnt % PERIOD) < VBLEN);
         frameCnt++;
      end
   endtask

   // Predict the state after the coming clock edge from the inputs now applied
   task automatic modelStep();
      int  s, lvl, p, back;
      bit  hit, timeout, rise;
      if (!rst_n) begin
         mPhase = P_IDLE; mFront = 0; mHave = 0; mPrev = 0; mVbPrev = 0;
         mTrig = 0; mBusy = 0; mWaitCnt = 0;
         expOut = 0; expOutKnown = 1; expEn = 0;
         modelReady = 1;
         return;
      end
      if (!modelReady) return;
      s    = int'(sample_in);
      lvl  = int'(trig_level);
      p    = int'(pix_x);
      back = 1 - mFront;
      if (p < DEPTH) begin
         expOut      = mBank[mFront][p];
         expOutKnown = mWritten[mFront][p];
      end
      expEn = mHave && (p < DEPTH);
      rise  = vblank && !mVbPrev;
      case (mPhase)
         P_IDLE: if (run) begin mPhase = P_WAIT; mWaitCnt = 0; end
         P_WAIT: begin
            if (!run) begin
               mPhase = P_IDLE;
            end else if (sample_valid) begin
               mWaitCnt++;
               hit = trig_rising ? (mPrev < lvl && s >= lvl) : (mPrev >= lvl && s < lvl);
               timeout = auto_mode && (mWaitCnt >= AUTO);
               if (hit || timeout) begin
                  mBank[back][0] = s; mWritten[back][0] = 1;
                  mWrIdx = 1; mSinceTrig = 0;
                  mKeep  = (decim == 0) ? 1 : int'(decim);
                  mTrig  = hit;
                  mPhase = P_CAP;
               end
            end
         end
         P_CAP: begin
            if (sample_valid) begin
               mSinceTrig++;
               if (mSinceTrig % mKeep == 0) begin
                  mBank[back][mWrIdx] = s; mWritten[back][mWrIdx] = 1;
                  mWrIdx++;
                  if (mWrIdx == DEPTH) mPhase = P_DONE;
               end
            end
         end
         default: begin
            if (rise) begin
               mFront = back; mHave = 1; swapCount++;
               if (run) begin mPhase = P_WAIT; mWaitCnt = 0; end
               else mPhase = P_IDLE;
            end
         end
      endcase
      if (sample_valid) mPrev = s;
      mVbPrev = vblank;
      mBusy   = (mPhase == P_WAIT) || (mPhase == P_CAP);
   endtask

   // Compare every output against the model prediction
   task automatic checkOutput();
      if (!modelReady) return;
      compare("busy", busy, mBusy);
      compare("triggered", triggered, mTrig);
      compare("wave_en", wave_en, expEn);
      if (expOutKnown) compare("wave_out", wave_out, expOut);
   endtask

   task automatic cycle();
      @(negedge clk);
      checkOutput();
      applyStimulus();
      modelStep();
   endtask

   task automatic cycles(input int n);
      for (int i = 0; i < n; i++) cycle();
   endtask

   task automatic waitSwap(input string name, input int budget);
      int s0 = swapCount;
      int n  = 0;
      while (swapCount == s0 && n < budget) begin cycle(); n++; end
      if (swapCount == s0) timeoutFail(name);
   endtask

   task automatic waitPhase(input string name, input int ph, input int budget);
      int n = 0;
      while (mPhase != ph && n < budget) begin cycle(); n++; end
      if (mPhase != ph) timeoutFail(name);
   endtask

   task automatic pulseReset();
      rstKnob = 0; cycle(); rstKnob = 1;
   endtask

   initial begin
      int k;
      // Reset
      rstKnob = 0;
      cycles(3);
      compare("reset_wave_en", wave_en, 0);
      compare("reset_busy", busy, 0);
      compare("reset_triggered", triggered, 0);
      compare("reset_wave_out", wave_out, 0);
      rstKnob = 1;

      // Rising trigger on a ramp, decim 1
      $display("[TB] rising trigger ramp");
      runKnob = 1;
      waitPhase("rise_capture_start", P_CAP, 3000);
      waitPhase("rise_capture_done", P_DONE, 3000);
      runKnob = 0;
      cycles(2);
      compare("rise_triggered", triggered, 1);
      waitSwap("rise_swap", 3000);
      pixMode = 1; pixFixed = 0; cycles(2);
      compare("rise_pix0", wave_out, 8192);
      compare("rise_pix0_en", wave_en, 1);
      pixFixed = 799; cycles(2);
      compare("rise_pix799", wave_out, 4592);
      pixFixed = 800; cycles(2);
      compare("bound_800_en", wave_en, 0);
      compare("bound_800_hold", wave_out, 4592);
      pixFixed = 1039; cycles(2);
      compare("bound_1039_en", wave_en, 0);
      compare("after_run0_busy", busy, 0);

      // Decimation by 4
      $display("[TB] decimation 4");
      decimKnob = 4; runKnob = 1;
      waitPhase("dec_capture_start", P_CAP, 3000);
      decimKnob = 7;
      waitPhase("dec_capture_done", P_DONE, 6000);
      runKnob = 0;
      waitSwap("dec_swap", 3000);
      pixFixed = 1; cycles(2);
      compare("dec_pix1", wave_out, 8256);
      pixFixed = 799; cycles(2);
      compare("dec_pix799", wave_out, 10176);

      // Auto timeout on a constant input
      $display("[TB] auto timeout");
      decimKnob = 1; autoKnob = 1; streamMode = 1; validPct = 0;
      pulseReset();
      runKnob = 1;
      cycles(2);
      validPct = 100;
      k = 0;
      while (k < 5000) begin
         cycle(); k++;
         if (busy == 1'b0) break;
      end
      compare("auto_samples_to_done", k, AUTO + DEPTH);
      compare("auto_triggered", triggered, 0);
      runKnob = 0;
      waitSwap("auto_swap", 3000);
      pixFixed = 5; cycles(2);
      compare("auto_pix5", wave_out, 100);

      // Normal mode with no trigger never captures
      autoKnob = 0;
      pulseReset();
      runKnob = 1;
      cycles(1500);
      compare("normal_busy", busy, 1);
      compare("normal_wave_en", wave_en, 0);
      runKnob = 0;
      cycles(3);

      // Capture completing on a vblank rise, with run dropped mid-capture
      $display("[TB] swap timing");
      streamMode = 0; levelKnob = 8192; pixFixed = 0; runKnob = 1;
      waitSwap("st_first_swap", 6000);
      levelKnob = 4096; vbMode = 1;
      waitPhase("st_capture_start", P_CAP, 3000);
      runKnob = 0;
      waitPhase("st_capture_done", P_DONE, 3000);
      cycles(50);
      compare("st_old_front", wave_out, 8192);
      compare("st_busy", busy, 0);
      waitSwap("st_second_swap", 3000);
      cycles(2);
      compare("st_new_front", wave_out, 4096);
      cycles(5);
      compare("st_idle_busy", busy, 0);

      // Reset in the middle of a capture
      $display("[TB] reset mid-capture");
      pixFixed = 3; levelKnob = 8192; runKnob = 1;
      waitPhase("rst_capture_start", P_CAP, 3000);
      cycles(100);
      pulseReset();
      cycle();
      compare("rst_wave_en", wave_en, 0);
      compare("rst_busy", busy, 0);
      waitSwap("rst_recapture", 8000);
      cycles(2);
      compare("rst_recapture_en", wave_en, 1);

      // Randomized mixes
      $display("[TB] randomized phase");
      for (int seg = 0; seg < 60; seg++) begin
         runKnob    = ($urandom_range(0, 9) < 8);
         autoKnob   = $urandom_range(0, 1);
         risingKnob = $urandom_range(0, 1);
         levelKnob  = $urandom_range(0, 16383);
         decimKnob  = $urandom_range(0, 5);
         streamMode = $urandom_range(0, 2);
         validPct   = $urandom_range(30, 100);
         pixMode    = ($urandom_range(0, 3) == 0);
         pixFixed   = ($urandom_range(0, 1) == 0) ? 800 : 1039;
         if ($urandom_range(0, 19) == 0) pulseReset();
         cycles(250);
      end

      cycles(2);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
